// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the column-serial multiplier sequencer.
// Sized around a 17-input column compressor with 7 carry lanes.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int PP_BITS     = 16;
    localparam int CARRY_LANES = 7;
    localparam int Y_W         = 17;

    // Number of partial-product bits that land in column col of an n x n product.
    function automatic int col_len(input int col, input int n);
        int lo;
        int hi;
        lo = (col - n + 1 > 0) ? col - n + 1 : 0;
        hi = (col < n - 1) ? col : n - 1;
        return (hi >= lo) ? hi - lo + 1 : 0;
    endfunction

endpackage

// File: rtl/mult_column_sequencer_pp_gen.sv
// Combinational partial-product column generator.
// Bit i of the column is a[i] & b[col-i] wherever both indices are in range.
module pp_column_gen
    import mult_seq_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = 6
) (
    input  logic [N-1:0]       a_i,
    input  logic [N-1:0]       b_i,
    input  logic [CW-1:0]      col_i,
    output logic [PP_BITS-1:0] pp_o
);

    // Select b[col-i] through a one-hot mask so no variable index is needed.
    always_comb begin
        pp_o = '0;
        for (int i = 0; i < N; i++) begin
            if (col_i >= CW'(i) && (col_i - CW'(i)) < CW'(N)) begin
                pp_o[i] = a_i[i] & (|(b_i & (N'(1) << (col_i - CW'(i)))));
            end
        end
    end

endmodule

// File: rtl/mult_column_sequencer.sv
// Column-serial unsigned N x N multiplier front end.
// Streams one partial-product column per cycle into an external compressor.
module mult_column_sequencer
    import mult_seq_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           a,
    input  logic [N-1:0]           b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N-1:0]         product,
    output logic                   carry_err,
    output logic [Y_W-1:0]         Y,
    output logic [CARRY_LANES-1:0] icins,
    output logic [CARRY_LANES-1:0] cins,
    input  logic [CARRY_LANES-1:0] icouts,
    input  logic [CARRY_LANES-1:0] couts,
    input  logic                   C,
    input  logic                   S
);

    if (N < 2 || N > PP_BITS) begin : g_bad_n
        $error("mult_column_sequencer: N must be in 2..16");
    end
    if (CW < $clog2(2 * N + 1)) begin : g_bad_cw
        $error("mult_column_sequencer: CW too narrow for 2N columns");
    end

    localparam logic [CW-1:0] LAST_COL = CW'(2 * N - 1);

    state_t                   state_q;
    logic [CW-1:0]            col_q;
    logic [N-1:0]             a_q;
    logic [N-1:0]             b_q;
    logic [2*N-1:0]           prod_q;
    logic [CARRY_LANES-1:0]   ic_q;
    logic [CARRY_LANES-1:0]   c_q;
    logic                     cf_q;
    logic                     err_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [PP_BITS-1:0]       pp;
    logic                     run;

    pp_column_gen #(
        .N  (N),
        .CW (CW)
    ) u_pp (
        .a_i   (a_q),
        .b_i   (b_q),
        .col_i (col_q),
        .pp_o  (pp)
    );

    // Sequencer FSM: accept operands, walk 2N columns, hold result until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            ic_q        <= '0;
            c_q         <= '0;
            cf_q        <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        col_q      <= '0;
                        prod_q     <= '0;
                        ic_q       <= '0;
                        c_q        <= '0;
                        cf_q       <= 1'b0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < 2 * N; i++) begin
                        if (col_q == CW'(i)) begin
                            prod_q[i] <= S;
                        end
                    end
                    ic_q  <= icouts;
                    c_q   <= couts;
                    cf_q  <= C;
                    col_q <= col_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        err_q       <= (|icouts) | (|couts) | C;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign run = (state_q == RUN);

    // Compressor drive is gated so it sees a quiet column outside RUN.
    always_comb begin
        Y     = '0;
        icins = '0;
        cins  = '0;
        if (run) begin
            Y     = {cf_q, pp};
            icins = ic_q;
            cins  = c_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = prod_q;
    assign carry_err = err_q;

    a_col_len : assert property (
        @(posedge clk) disable iff (reset)
        run |-> ($countones(pp) <= col_len(int'(col_q), N))
    );

    a_hs_excl : assert property (
        @(posedge clk) disable iff (reset)
        !(in_ready_q && out_valid_q)
    );

endmodule

// File: tb/tb_mult_column_sequencer.sv
// Bench for mult_column_sequencer with a behavioural column compressor.
// Scoreboard queue of expected products, popped by an output monitor.
module tb_mult_column_sequencer;

    localparam int N  = 16;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [2*N-1:0] product;
    logic          carry_err;
    logic [16:0]   Y;
    logic [6:0]    icins;
    logic [6:0]    cins;
    logic [6:0]    icouts;
    logic [6:0]    couts;
    logic          C;
    logic          S;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic ov_seen = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mult_column_sequencer #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .carry_err (carry_err),
        .Y         (Y),
        .icins     (icins),
        .cins      (cins),
        .icouts    (icouts),
        .couts     (couts),
        .C         (C),
        .S         (S)
    );

    // Behavioural compressor: column total T, S = T[0], T>>1 spread over carries.
    int tot;
    int kc;
    always_comb begin
        tot    = $countones(Y) + $countones(icins) + $countones(cins);
        kc     = tot >> 1;
        S      = tot[0];
        couts  = '0;
        icouts = '0;
        for (int i = 0; i < 7; i++) begin
            if (kc > i) couts[i] = 1'b1;
            if (kc > 7 + i) icouts[i] = 1'b1;
        end
        C = (kc > 14);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Output monitor: latency on each rising out_valid, scoreboard on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !ov_seen) begin
                check("latency", 64'(cyc - acc_cyc), 64'(2 * N));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("product", product, exp_q.pop_front());
                    check("carry_err", carry_err, 0);
                end
            end
        end
        ov_seen = out_valid;
    end

    task automatic accept(input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] ev, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            return;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int bad;
        int prev;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_carry_err", carry_err, 0);
        check("rst_Y", {Y, icins, cins}, 0);
        @(negedge clk);
        reset = 1'b0;

        accept(16'h0000, 16'hBEEF, 32'h0000_0000, 0);
        drain();

        accept(16'h0003, 16'h0005, 32'h0000_000F, 0);
        bad = 0;
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            if (k == 0) check("col0_y", Y, 17'h00001);
            if (k >= 4 && Y != '0) bad++;
        end
        check("y_tail_zero", 64'(bad), 0);
        drain();

        accept(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) check("col15_y", Y[15:0], 16'hFFFF);
        end
        drain();

        out_ready = 1'b0;
        accept(16'h1234, 16'h5678, 32'h0626_0060, 0);
        for (int k = 0; k < 6; k++) @(negedge clk);
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        bad = 0;
        while (!out_valid && bad < 60) begin
            @(negedge clk);
            bad++;
        end
        check("stall_valid", out_valid, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (product != 32'h0626_0060 || !out_valid || in_ready) bad++;
        end
        check("stall_hold", 64'(bad), 0);
        check("stall_product", product, 32'h0626_0060);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_ready", {in_ready, out_valid}, 2'b10);
        drain();

        accept(16'hFFFF, 16'h0101, 32'h0100_FEFF, 0);
        for (int k = 0; k < 10; k++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("abort_idle", {in_ready, out_valid}, 2'b10);
        check("abort_product", product, 0);
        check("abort_Y", Y, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("abort_no_valid", 64'(bad), 0);
        accept(16'h0002, 16'h0007, 32'h0000_000E, 0);
        drain();

        bad = 0;
        prev = 0;
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k == 0) begin
                ra = 16'hFFFF;
                rb = 16'h0001;
            end
            accept(ra, rb, 32'(ra) * 32'(rb), 1);
            if (k > 0 && acc_cyc - prev != 2 * N + 2) bad++;
            prev = acc_cyc;
        end
        check("throughput", 64'(bad), 0);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
